// File: rtl/mem_writeback.sv
// mem_writeback: MEM-WB stage of the pipelined CPU.
// Registers EX results (EX/MEM rank), performs the data-memory access and
// jump resolution, and registers the write-back / redirect outputs (MEM/WB
// rank) that feed fetch_decode. One instruction per cycle, no stalls.
module mem_writeback #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [4:0]  in_pc,
    input  logic [31:0] in_alu_res,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_write_reg,
    input  logic        in_reg_wrenable,
    input  logic        in_mem_wrenable,
    input  logic        in_mem_to_reg,
    input  logic [3:0]  in_jmp_type,
    output logic        wb_reg_wrenable,
    output logic [4:0]  wb_write_reg,
    output logic [31:0] wb_write_data,
    output logic        should_jump,
    output logic [4:0]  jump_pc,
    output logic        flush,
    output logic [31:0] retire_count
);

    localparam logic [3:0] JMP_ALWAYS  = 4'd1;
    localparam logic [3:0] JMP_ZERO    = 4'd2;
    localparam logic [3:0] JMP_NONZERO = 4'd3;

    // EX/MEM rank
    logic        em_valid;
    logic [4:0]  em_pc;
    logic [31:0] em_alu_res;
    logic [31:0] em_store_data;
    logic [4:0]  em_write_reg;
    logic        em_reg_wrenable;
    logic        em_mem_wrenable;
    logic        em_mem_to_reg;
    logic [3:0]  em_jmp_type;

    // Data memory and decoded access
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] em_addr;
    logic              take;
    logic              do_store;

    // EX/MEM valid: drop the instruction arriving in a taken branch's shadow
    always_ff @(posedge clk) begin
        if (reset) begin
            em_valid <= 1'b0;
        end else begin
            em_valid <= in_valid & ~should_jump;
        end
    end

    // EX/MEM payload: captured whenever EX presents a result
    // NOTE: payload registers carry no reset; em_valid alone qualifies them,
    // so resetting the wide datapath would only cost logic.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            em_pc           <= in_pc;
            em_alu_res      <= in_alu_res;
            em_store_data   <= in_store_data;
            em_write_reg    <= in_write_reg;
            em_reg_wrenable <= in_reg_wrenable;
            em_mem_wrenable <= in_mem_wrenable;
            em_mem_to_reg   <= in_mem_to_reg;
            em_jmp_type     <= in_jmp_type;
        end
    end

    // Word address, store qualification and branch decision for the EX/MEM instruction
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        em_addr  = em_alu_res[ADDR_W+1:2];
        do_store = em_valid & em_mem_wrenable & ~reset;
        take     = 1'b0;
        case (em_jmp_type)
            JMP_ALWAYS:  take = 1'b1;
            JMP_ZERO:    take = (em_alu_res == 32'd0);
            JMP_NONZERO: take = (em_alu_res != 32'd0);
            default:     take = 1'b0;
        endcase
    end

    // Data memory write port; a store caught by reset is abandoned
    // NOTE: memory contents are deliberately never reset so it maps to a RAM macro.
    always_ff @(posedge clk) begin
        if (do_store) begin
            mem[em_addr] <= em_store_data;
        end
    end

    // MEM/WB rank: write-back, redirect and retire counter
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_reg_wrenable <= 1'b0;
            wb_write_reg    <= 5'd0;
            wb_write_data   <= 32'd0;
            should_jump     <= 1'b0;
            jump_pc         <= 5'd0;
            retire_count    <= 32'd0;
        end else begin
            wb_reg_wrenable <= em_valid & em_reg_wrenable & ~em_mem_wrenable;
            should_jump     <= em_valid & take;
            if (em_valid) begin
                wb_write_reg  <= em_write_reg;
                wb_write_data <= em_mem_to_reg ? mem[em_addr] : em_alu_res;
                retire_count  <= retire_count + 32'd1;
                if (take) begin
                    jump_pc <= em_pc;
                end
            end
        end
    end

    assign flush = should_jump;

endmodule

// File: tb/tb_mem_writeback.sv
// Self-checking bench for mem_writeback: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a transaction model.
module tb_mem_writeback;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [4:0]  in_pc;
    logic [31:0] in_alu_res;
    logic [31:0] in_store_data;
    logic [4:0]  in_write_reg;
    logic        in_reg_wrenable;
    logic        in_mem_wrenable;
    logic        in_mem_to_reg;
    logic [3:0]  in_jmp_type;
    logic        wb_reg_wrenable;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        should_jump;
    logic [4:0]  jump_pc;
    logic        flush;
    logic [31:0] retire_count;

    always #5 clk = ~clk;

    mem_writeback #(.DEPTH(DEPTH), .ADDR_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_pc           (in_pc),
        .in_alu_res      (in_alu_res),
        .in_store_data   (in_store_data),
        .in_write_reg    (in_write_reg),
        .in_reg_wrenable (in_reg_wrenable),
        .in_mem_wrenable (in_mem_wrenable),
        .in_mem_to_reg   (in_mem_to_reg),
        .in_jmp_type     (in_jmp_type),
        .wb_reg_wrenable (wb_reg_wrenable),
        .wb_write_reg    (wb_write_reg),
        .wb_write_data   (wb_write_data),
        .should_jump     (should_jump),
        .jump_pc         (jump_pc),
        .flush           (flush),
        .retire_count    (retire_count)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  pc;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  wr;
        logic        rwe;
        logic        mwe;
        logic        m2r;
        logic [3:0]  jt;
    } instr_t;

    typedef struct {
        instr_t      i;
        logic        x_en;
        logic [4:0]  x_wr;
        logic [31:0] x_wd;
        logic        x_sj;
        logic [4:0]  x_jpc;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction model: architectural memory, the instruction awaiting its
    // memory access, and the outputs it must produce one edge later.
    logic [31:0] m_mem [DEPTH];
    instr_t      m_pend;
    bit          m_pend_v = 1'b0;
    bit          e_en = 1'b0;
    bit          e_sj = 1'b0;
    logic [4:0]  e_wr = '0;
    logic [31:0] e_wd = '0;
    logic [4:0]  e_jpc = '0;
    logic [31:0] e_retire = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic instr_t nop_i();
        instr_t r;
        r = '{valid: 1'b0, pc: 5'd0, alu: 32'd0, sd: 32'd0, wr: 5'd0,
              rwe: 1'b0, mwe: 1'b0, m2r: 1'b0, jt: 4'd0};
        return r;
    endfunction

    function automatic instr_t alu_i(input logic [4:0] wr, input logic [31:0] v);
        instr_t r = nop_i();
        r.valid = 1'b1; r.wr = wr; r.alu = v; r.rwe = 1'b1;
        return r;
    endfunction

    function automatic instr_t st_i(input logic [31:0] a, input logic [31:0] d);
        instr_t r = nop_i();
        r.valid = 1'b1; r.alu = a; r.sd = d; r.mwe = 1'b1;
        return r;
    endfunction

    function automatic instr_t ld_i(input logic [31:0] a, input logic [4:0] wr);
        instr_t r = nop_i();
        r.valid = 1'b1; r.alu = a; r.wr = wr; r.rwe = 1'b1; r.m2r = 1'b1;
        return r;
    endfunction

    function automatic instr_t br_i(input logic [3:0] jt, input logic [31:0] v,
                                    input logic [4:0] pc, input logic [4:0] wr, input logic rwe);
        instr_t r = nop_i();
        r.valid = 1'b1; r.jt = jt; r.alu = v; r.pc = pc; r.wr = wr; r.rwe = rwe;
        return r;
    endfunction

    function automatic logic [31:0] preload(input int w);
        return 32'hC0DE_0000 | (w * 32'h0101);
    endfunction

    // Apply one instruction for one clock, advance the model, compare #1 after the edge.
    task automatic cycle(input instr_t i, input bit rst);
        bit new_v;
        bit tk;
        int a;
        reset           = rst;
        in_valid        = i.valid;
        in_pc           = i.pc;
        in_alu_res      = i.alu;
        in_store_data   = i.sd;
        in_write_reg    = i.wr;
        in_reg_wrenable = i.rwe;
        in_mem_wrenable = i.mwe;
        in_mem_to_reg   = i.m2r;
        in_jmp_type     = i.jt;
        @(posedge clk);
        new_v = i.valid && !e_sj;
        if (rst) begin
            e_en = 0; e_sj = 0; e_wr = '0; e_wd = '0; e_jpc = '0; e_retire = '0;
            m_pend_v = 0;
        end else begin
            e_en = 0;
            e_sj = 0;
            if (m_pend_v) begin
                a = int'((m_pend.alu / 4) % DEPTH);
                e_retire = e_retire + 1;
                e_wr = m_pend.wr;
                e_wd = m_pend.m2r ? m_mem[a] : m_pend.alu;
                if (m_pend.mwe) m_mem[a] = m_pend.sd;
                else            e_en = m_pend.rwe;
                tk = (m_pend.jt == 4'd1) || (m_pend.jt == 4'd2 && m_pend.alu == 0) ||
                     (m_pend.jt == 4'd3 && m_pend.alu != 0);
                if (tk) begin
                    e_sj  = 1;
                    e_jpc = m_pend.pc;
                end
            end
            m_pend   = i;
            m_pend_v = new_v;
        end
        #1;
        check("wb_reg_wrenable", wb_reg_wrenable, e_en);
        check("should_jump", should_jump, e_sj);
        check("flush", flush, e_sj);
        check("jump_pc", jump_pc, e_jpc);
        check("retire_count", retire_count, e_retire);
        if (e_en || rst) begin
            check("wb_write_reg", wb_write_reg, e_wr);
            check("wb_write_data", wb_write_data, e_wd);
        end
    endtask

    function automatic instr_t rand_i();
        instr_t r = nop_i();
        int kind = $urandom_range(0, 9);
        r.valid = ($urandom_range(0, 7) != 0);
        r.pc    = 5'($urandom);
        r.alu   = $urandom;
        r.sd    = $urandom;
        r.wr    = 5'($urandom);
        r.rwe   = 1'($urandom);
        r.mwe   = (kind < 2) || (kind == 9 && r.rwe);
        r.m2r   = (kind >= 2 && kind < 5) || kind == 9;
        if (kind == 5 || kind == 6) begin
            r.jt = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) r.alu = 32'd0;
        end
        return r;
    endfunction

    vec_t        vecs [12];
    int          pulses;
    bit          r7_seen;
    logic [31:0] base;

    initial begin
        // Directed vectors, each applied in isolation
        vecs[0]  = '{alu_i(5'd5, 32'h1234),                 1, 5'd5, 32'h1234,     0, 5'd0};
        vecs[1]  = '{st_i(32'h8, 32'hDEADBEEF),             0, 5'd0, 32'h0,        0, 5'd0};
        vecs[2]  = '{ld_i(32'h8, 5'd3),                     1, 5'd3, 32'hDEADBEEF, 0, 5'd0};
        vecs[3]  = '{st_i(32'h80, 32'hA5),                  0, 5'd0, 32'h0,        0, 5'd0};
        vecs[4]  = '{ld_i(32'h0, 5'd9),                     1, 5'd9, 32'hA5,       0, 5'd0};
        vecs[5]  = '{br_i(4'd1, 32'h77, 5'h0A, 5'd1, 1'b1), 1, 5'd1, 32'h77,       1, 5'h0A};
        vecs[6]  = '{br_i(4'd2, 32'h5, 5'h03, 5'd0, 1'b0),  0, 5'd0, 32'h0,        0, 5'd0};
        vecs[7]  = '{br_i(4'd3, 32'h5, 5'h1F, 5'd0, 1'b0),  0, 5'd0, 32'h0,        1, 5'h1F};
        vecs[8]  = '{br_i(4'd7, 32'h0, 5'h02, 5'd2, 1'b1),  1, 5'd2, 32'h0,        0, 5'd0};
        vecs[9]  = '{st_i(32'hC, 32'h5A5A),                 0, 5'd0, 32'h0,        0, 5'd0};
        vecs[10] = '{ld_i(32'hC, 5'd4),                     1, 5'd4, 32'h5A5A,     0, 5'd0};
        vecs[11] = '{ld_i(32'hFFFF_FF0B, 5'd6),             1, 5'd6, 32'hDEADBEEF, 0, 5'd0};
        vecs[9].i.rwe = 1'b1;
        vecs[9].i.m2r = 1'b1;

        cycle(nop_i(), 1'b1);
        cycle(nop_i(), 1'b1);
        check("reset_wb_write_reg", wb_write_reg, 5'd0);
        check("reset_wb_write_data", wb_write_data, 32'd0);

        for (int w = 0; w < DEPTH; w++) cycle(st_i(32'(w * 4), preload(w)), 1'b0);
        cycle(nop_i(), 1'b0);
        cycle(nop_i(), 1'b0);

        for (int v = 0; v < 12; v++) begin
            cycle(vecs[v].i, 1'b0);
            cycle(nop_i(), 1'b0);
            check($sformatf("vec%0d_en", v), wb_reg_wrenable, vecs[v].x_en);
            check($sformatf("vec%0d_sj", v), should_jump, vecs[v].x_sj);
            if (vecs[v].x_en) begin
                check($sformatf("vec%0d_wr", v), wb_write_reg, vecs[v].x_wr);
                check($sformatf("vec%0d_wd", v), wb_write_data, vecs[v].x_wd);
            end
            if (vecs[v].x_sj) check($sformatf("vec%0d_jpc", v), jump_pc, vecs[v].x_jpc);
            cycle(nop_i(), 1'b0);
        end

        // Taken branch: the op arriving while should_jump is high is squashed
        for (int rep = 0; rep < 2; rep++) begin
            base = retire_count;
            r7_seen = 0;
            cycle(br_i(4'd2, 32'(rep), 5'h11, 5'd0, 1'b0), 1'b0);
            cycle(nop_i(), 1'b0);
            if (rep == 0) check("branch_jpc", jump_pc, 5'h11);
            cycle(alu_i(5'd7, 32'h7777), 1'b0);
            for (int k = 0; k < 3; k++) begin
                cycle(nop_i(), 1'b0);
                if (wb_reg_wrenable && wb_write_reg == 5'd7) r7_seen = 1;
            end
            check($sformatf("branch%0d_r7_written", rep), r7_seen, rep);
            check($sformatf("branch%0d_retired", rep), retire_count - base, 32'd2 - 32'(rep == 0));
        end

        // Reset while a store to 0x4 sits in the EX/MEM rank
        cycle(st_i(32'h4, 32'h1111_2222), 1'b0);
        cycle(nop_i(), 1'b1);
        check("midreset_retire", retire_count, 32'd0);
        cycle(ld_i(32'h4, 5'd8), 1'b0);
        cycle(nop_i(), 1'b0);
        cycle(nop_i(), 1'b0);
        check("midreset_load_old", wb_write_data, preload(1));

        // Throughput: 40 back-to-back ALU ops
        cycle(nop_i(), 1'b1);
        pulses = 0;
        for (int k = 0; k < 42; k++) begin
            cycle(k < 40 ? alu_i(5'(k), 32'(k * 3 + 1)) : nop_i(), 1'b0);
            if (wb_reg_wrenable) pulses++;
        end
        check("throughput_pulses", pulses, 40);
        check("throughput_retire", retire_count, 32'd40);

        // Randomized traffic with occasional reset
        for (int k = 0; k < 800; k++) cycle(rand_i(), $urandom_range(0, 63) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
- MEM-WB stage of the pipelined CPU; consumes the EX stage results (target PC, ALU result, store data, control) and performs the data-memory access.
- Resolves jumps/branches and drives the write port and jump inputs of fetch_decode, closing the loop back to stage 1.
- Two internal register ranks (EX/MEM, MEM/WB) plus a synchronous word-addressed data memory.

Parameters:
- DEPTH, 32, data memory depth in 32-bit words (power of two)
- ADDR_W, 5, log2(DEPTH); word address = alu_res[ADDR_W+1:2]

Ports:
- clk  in  1  stage clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  EX result valid this cycle
- in_pc  in  5  jump target PC computed by EX
- in_alu_res  in  32  ALU result / memory byte address / branch compare
- in_store_data  in  32  data for stores (rd2)
- in_write_reg  in  5  destination register
- in_reg_wrenable  in  1  instruction writes a register
- in_mem_wrenable  in  1  instruction is a store
- in_mem_to_reg  in  1  instruction is a load
- in_jmp_type  in  4  0 none, 1 unconditional, 2 branch-if-zero, 3 branch-if-nonzero, others treated as 0
- wb_reg_wrenable  out  1  to fetch_decode reg_wrenable
- wb_write_reg  out  5  to fetch_decode write_reg
- wb_write_data  out  32  to fetch_decode write_data
- should_jump  out  1  one-cycle redirect pulse to fetch_decode
- jump_pc  out  5  redirect target
- flush  out  1  equals should_jump; kills younger instructions in earlier stages
- retire_count  out  32  instructions retired

Behaviour:
- Reset (edge with reset=1): all valid bits, wb_reg_wrenable, should_jump, flush = 0; wb_write_reg, wb_write_data, jump_pc, retire_count = 0. Memory contents not reset. Reset wins over all other activity and discards in-flight instructions in both ranks.
- Edge E0: EX/MEM rank samples all in_* when in_valid=1; else the rank's valid bit becomes 0.
- Squash: if should_jump=1 during the cycle before E0, the instruction sampled at E0 enters with valid=0 (the branch shadow).
- Edge E1 (EX/MEM valid):
  - Store (mem_wrenable=1): mem[word addr] <= store_data; no register write even if reg_wrenable=1; store beats load if both flags are set.
  - Load (mem_to_reg=1, not a store): synchronous read; wb_write_data = mem word.
  - Otherwise wb_write_data = alu_res.
  - wb_reg_wrenable = valid & reg_wrenable & ~mem_wrenable.
  - wb_write_reg = write_reg.
- Write-back outputs are registered at E1 and held one cycle. Total latency = 2 edges from in_valid to wb_*. wb_reg_wrenable is a one-cycle pulse per instruction.
- Jump resolution at E1: take = type1, or (type2 & alu_res==0), or (type3 & alu_res!=0).
  - should_jump = valid & take, one cycle.
  - jump_pc = pc (loaded only when taken, otherwise held).
  - A taken branch may also write a register (link) in the same cycle.
- Back-to-back: one instruction per cycle, no stalls. A store followed immediately by a load to the same address returns the new data (write completes at E1 of the store, read at E1 of the load, one edge later).
- Address wrap: upper alu_res bits above ADDR_W+1 are ignored; the low two bits are ignored.
- retire_count increments by 1 at E1 for every valid non-squashed instruction; wraps 0xFFFFFFFF -> 0.
- reset asserted mid-stream: the next cycle shows all enables 0; a store in the EX/MEM rank at that edge is not performed.

Test Plan:
- ALU writeback: in_valid, alu_res=0x1234, write_reg=5, reg_wrenable=1 -> two edges later wb_reg_wrenable=1, wb_write_reg=5, wb_write_data=0x1234, for exactly one cycle; retire_count=1.
- Store then load: store 0xDEADBEEF to addr 0x8, next cycle load addr 0x8 to r3 -> load's write-back carries r3=0xDEADBEEF; the store produces no wb_reg_wrenable.
- Branch: type2 with alu_res=0, pc=0x11, followed by a valid ALU op to r7 -> should_jump=1, jump_pc=0x11, flush=1 for one cycle; the r7 op is squashed (no write-back, not counted). Repeat with alu_res=1 -> no jump, r7 written.
- Address wrap: store 0xA5 at addr 0x80 (DEPTH=32), load addr 0x0 -> reads 0xA5.
- Reset mid-operation: a store to addr 0x4 is in the EX/MEM rank when reset pulses -> all outputs 0 next cycle; a later load of addr 0x4 returns the previous contents; retire_count=0.
- Throughput: 40 consecutive valid ALU ops -> 40 consecutive wb pulses with no gaps, retire_count=40.
